// File: rtl/button_mode_counter.sv
// -----------------------------------------------------------------------------
// button_mode_counter
//   Steps a mode counter over 0..NUM_MODES-1 from three debounced push-buttons
//   (up / down / clear). Each button is synchronised into clk and rising-edge
//   detected. Up/down wrap or saturate at the ends depending on WRAP.
//
//   Optional feature: define AUTO_REPEAT_EN to add a hold-to-repeat FSM.
//   Holding up or down then steps again after HOLD_CYCLES, and every
//   REPEAT_CYCLES after that. With the macro undefined, no FSM or timer is
//   built and HOLD_CYCLES/REPEAT_CYCLES only take part in the parameter check.
//
// Ports
//   clk        in   1          system clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   btn_up     in   1          debounced level, async to clk
//   btn_down   in   1          debounced level, async to clk
//   btn_clear  in   1          debounced level, async to clk
//   mode       out  CTR_W      current mode, binary (registered)
//   mode_led   out  NUM_MODES  one-hot of mode (registered)
//   changed    out  1          one-cycle pulse when mode takes a new value (registered)
// -----------------------------------------------------------------------------
module button_mode_counter #(
    parameter int unsigned NUM_MODES     = 4,
    parameter int unsigned CTR_W         = 2,
    parameter int unsigned WRAP          = 1,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_clear,
    output logic [CTR_W-1:0]     mode,
    output logic [NUM_MODES-1:0] mode_led,
    output logic                 changed
);

    localparam int unsigned BTN_N      = 3;
    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DN     = 1;
    localparam int unsigned BTN_CLR    = 2;
    localparam logic [CTR_W-1:0] MODE_LAST = CTR_W'(NUM_MODES - 1);

    // Elaboration-time sanity check of the parameter set
    if (NUM_MODES < 2 || CTR_W < $clog2(NUM_MODES) ||
        HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("button_mode_counter: illegal parameter combination");
    end

    // Synchroniser (s1, s2) plus previous-value register (s3) for each button
    logic [BTN_N-1:0] btn_vec;
    logic [BTN_N-1:0] s1_q;
    logic [BTN_N-1:0] s2_q;
    logic [BTN_N-1:0] s3_q;
    logic [BTN_N-1:0] rise;

    assign btn_vec = {btn_clear, btn_down, btn_up};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= btn_vec;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    logic up_rise;
    logic down_rise;
    logic clear_rise;

    assign up_rise    = rise[BTN_UP];
    assign down_rise  = rise[BTN_DN];
    assign clear_rise = rise[BTN_CLR];

    logic up_step;
    logic down_step;

`ifdef AUTO_REPEAT_EN
    // Hold-to-repeat: one FSM shared by both directions, direction latched on press
    localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    rpt_state_e       rpt_state_q;
    logic             rpt_dir_dn_q;
    logic [TMR_W-1:0] rpt_tmr_q;

    logic rpt_held;
    logic rpt_opp_rise;
    logic rpt_abort;
    logic rpt_tmr_last;
    logic rpt_fire;

    assign rpt_held     = rpt_dir_dn_q ? s2_q[BTN_DN] : s2_q[BTN_UP];
    assign rpt_opp_rise = rpt_dir_dn_q ? up_rise : down_rise;
    // Leaving HOLD/REPEAT: button released, or clear / opposite press takes over
    assign rpt_abort    = clear_rise | rpt_opp_rise | ~rpt_held;
    assign rpt_tmr_last = (rpt_state_q == RPT_HOLD) ?
                          (rpt_tmr_q == TMR_W'(HOLD_CYCLES - 1)) :
                          (rpt_tmr_q == TMR_W'(REPEAT_CYCLES - 1));
    assign rpt_fire     = (rpt_state_q != RPT_IDLE) & ~rpt_abort & rpt_tmr_last;

    assign up_step   = up_rise   | (rpt_fire & ~rpt_dir_dn_q);
    assign down_step = down_rise | (rpt_fire &  rpt_dir_dn_q);

    // Repeat FSM and timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_state_q  <= RPT_IDLE;
            rpt_dir_dn_q <= 1'b0;
            rpt_tmr_q    <= '0;
        end else begin
            case (rpt_state_q)
                RPT_IDLE: begin
                    // Simultaneous up+down cancel out, so only a lone press arms the FSM
                    if (!clear_rise && (up_rise ^ down_rise)) begin
                        rpt_state_q  <= RPT_HOLD;
                        rpt_dir_dn_q <= down_rise;
                        rpt_tmr_q    <= '0;
                    end
                end
                RPT_HOLD, RPT_REPEAT: begin
                    if (rpt_abort) begin
                        rpt_state_q <= RPT_IDLE;
                        rpt_tmr_q   <= '0;
                    end else if (rpt_tmr_last) begin
                        rpt_state_q <= RPT_REPEAT;
                        rpt_tmr_q   <= '0;
                    end else begin
                        rpt_tmr_q <= rpt_tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    rpt_state_q <= RPT_IDLE;
                    rpt_tmr_q   <= '0;
                end
            endcase
        end
    end
`else
    assign up_step   = up_rise;
    assign down_step = down_rise;
`endif

    // Mode counter
    logic [CTR_W-1:0]     mode_q;
    logic [CTR_W-1:0]     mode_d;
    logic [CTR_W-1:0]     mode_inc;
    logic [CTR_W-1:0]     mode_dec;
    logic [NUM_MODES-1:0] mode_led_q;
    logic                 changed_q;

    // Explicit end handling keeps mode inside 0..NUM_MODES-1 for any NUM_MODES
    always_comb begin
        mode_inc = mode_q + CTR_W'(1);
        mode_dec = mode_q - CTR_W'(1);
        if (mode_q == MODE_LAST) begin
            mode_inc = (WRAP != 0) ? '0 : mode_q;
        end
        if (mode_q == '0) begin
            mode_dec = (WRAP != 0) ? MODE_LAST : mode_q;
        end
    end

    // Step priority: clear > (up & down cancel) > up > down
    always_comb begin
        mode_d = mode_q;
        if (clear_rise) begin
            mode_d = '0;
        end else if (up_step && down_step) begin
            mode_d = mode_q;
        end else if (up_step) begin
            mode_d = mode_inc;
        end else if (down_step) begin
            mode_d = mode_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= '0;
            mode_led_q <= NUM_MODES'(1);
            changed_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            mode_led_q <= NUM_MODES'(1) << mode_d;
            changed_q  <= (mode_d != mode_q);
        end
    end

    assign mode     = mode_q;
    assign mode_led = mode_led_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_button_mode_counter.sv
// -----------------------------------------------------------------------------
// tb_button_mode_counter
//   Directed bench. Two instances share clock, reset and buttons:
//     dut_a : NUM_MODES=4, WRAP=1
//     dut_b : NUM_MODES=5, CTR_W=3, WRAP=0
//   Both use HOLD_CYCLES=10, REPEAT_CYCLES=4 (only relevant with AUTO_REPEAT_EN).
// -----------------------------------------------------------------------------
module tb_button_mode_counter;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clear;

    logic [1:0] mode_a;
    logic [3:0] led_a;
    logic       changed_a;
    logic [2:0] mode_b;
    logic [4:0] led_b;
    logic       changed_b;

    int n_checks = 0;
    int n_errors = 0;

    button_mode_counter #(
        .NUM_MODES(4), .CTR_W(2), .WRAP(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
        .mode(mode_a), .mode_led(led_a), .changed(changed_a)
    );

    button_mode_counter #(
        .NUM_MODES(5), .CTR_W(3), .WRAP(0), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
        .mode(mode_b), .mode_led(led_b), .changed(changed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Press {clear,down,up} for 4 edges; checks latency, result and pulse width
    task automatic press(input string tag, input logic [2:0] btns,
                         input int exp_a, input int exp_ca,
                         input int exp_b, input int exp_cb);
        @(negedge clk);
        {btn_clear, btn_down, btn_up} = btns;
        @(posedge clk);                       // edge N
        @(posedge clk); #1;                   // edge N+1: not yet visible
        check_eq({tag, "_lat_chg_a"}, 32'(changed_a), 32'd0);
        @(posedge clk); #1;                   // edge N+2: updated
        check_eq({tag, "_mode_a"}, 32'(mode_a),    32'(exp_a));
        check_eq({tag, "_led_a"},  32'(led_a),     32'd1 << exp_a);
        check_eq({tag, "_chg_a"},  32'(changed_a), 32'(exp_ca));
        check_eq({tag, "_mode_b"}, 32'(mode_b),    32'(exp_b));
        check_eq({tag, "_led_b"},  32'(led_b),     32'd1 << exp_b);
        check_eq({tag, "_chg_b"},  32'(changed_b), 32'(exp_cb));
        @(posedge clk); #1;                   // edge N+3: pulse gone
        check_eq({tag, "_pulse_a"}, 32'(changed_a), 32'd0);
        check_eq({tag, "_pulse_b"}, 32'(changed_b), 32'd0);
        @(negedge clk);
        {btn_clear, btn_down, btn_up} = 3'b000;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_clear = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mode_a", 32'(mode_a),    32'd0);
        check_eq("rst_led_a",  32'(led_a),     32'd1);
        check_eq("rst_chg_a",  32'(changed_a), 32'd0);
        check_eq("rst_mode_b", 32'(mode_b),    32'd0);
        check_eq("rst_led_b",  32'(led_b),     32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Up presses: A wraps 3->0, B saturates at 4
        press("up1", 3'b001, 1, 1, 1, 1);
        press("up2", 3'b001, 2, 1, 2, 1);
        press("up3", 3'b001, 3, 1, 3, 1);
        press("up4", 3'b001, 0, 1, 4, 1);
        press("up5", 3'b001, 1, 1, 4, 0);
        press("up6", 3'b001, 2, 1, 4, 0);

        // Clear, then down at 0: A wraps to 3, B holds
        press("clr1", 3'b100, 0, 1, 0, 1);
        press("dn0",  3'b010, 3, 1, 0, 0);
        press("clr2", 3'b100, 0, 1, 0, 0);

        // Simultaneous presses
        press("up7",   3'b001, 1, 1, 1, 1);
        press("up8",   3'b001, 2, 1, 2, 1);
        press("updn",  3'b011, 2, 0, 2, 0);
        press("clrup", 3'b101, 0, 1, 0, 1);
        press("clr0",  3'b100, 0, 0, 0, 0);

        // Asynchronous reset mid-count, checked before any clock edge
        press("up9",  3'b001, 1, 1, 1, 1);
        press("up10", 3'b001, 2, 1, 2, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_mode_a", 32'(mode_a),    32'd0);
        check_eq("arst_led_a",  32'(led_a),     32'd1);
        check_eq("arst_chg_a",  32'(changed_a), 32'd0);
        check_eq("arst_mode_b", 32'(mode_b),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

`ifndef AUTO_REPEAT_EN
        // Long hold gives exactly one step
        @(negedge clk);
        btn_up = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (changed_a) cnt++;
        end
        check_eq("hold_steps_a", 32'(cnt),    32'd1);
        check_eq("hold_mode_a",  32'(mode_a), 32'd1);
        check_eq("hold_mode_b",  32'(mode_b), 32'd1);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (4) @(posedge clk);

        // Sub-cycle down glitch between edges is never sampled
        @(posedge clk);
        #2 btn_down = 1'b1;
        #3 btn_down = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (changed_a) cnt++;
        end
        check_eq("glitch_chg_a",  32'(cnt),    32'd0);
        check_eq("glitch_mode_a", 32'(mode_a), 32'd1);
`else
        // Auto-repeat: hold up for 30 edges from mode 0
        @(negedge clk);
        btn_up = 1'b1;
        @(posedge clk);                       // edge N
        @(posedge clk);                       // edge N+1
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;               // edge N+2+k
            if (k == 27) btn_up = 1'b0;       // low before edge N+30
            check_eq($sformatf("rpt_chg_a_k%0d", k), 32'(changed_a),
                     32'((k == 0) || (k == 10) || (k == 14) || (k == 18) ||
                         (k == 22) || (k == 26)));
        end
        check_eq("rpt_mode_a", 32'(mode_a), 32'd2);
        check_eq("rpt_led_a",  32'(led_a),  32'd4);
        check_eq("rpt_mode_b", 32'(mode_b), 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
